// File: rtl/btn_sched_pkg.sv
// btn_sched_pkg: shared channel-state type and default repeat timing
package btn_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} ch_state_t;
  localparam int DEF_REPEAT_DELAY = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;
endpackage

// File: rtl/btn_repeat_timer.sv
// btn_repeat_timer: per-channel press/auto-repeat event generator
import btn_sched_pkg::*;
module btn_repeat_timer #(
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_state,
  input  logic pb_down,
  input  logic rpt_en,
  output logic evt_press,
  output logic evt_rpt
);
  ch_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, lim;
  // state and hold counter registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // next state: a fresh press always restarts the delay, release drops to idle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    evt_press = 1'b0;
    evt_rpt = 1'b0;
    lim = (state == ST_DELAY) ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
    if (pb_down) begin
      evt_press = 1'b1;
      cnt_n = '0;
      state_n = ST_DELAY;
    end else if (state != ST_IDLE) begin
      if (!pb_state || !rpt_en) begin
        state_n = ST_IDLE;
        cnt_n = '0;
      end else if (cnt == lim) begin
        evt_rpt = 1'b1;
        cnt_n = '0;
        state_n = ST_REPEAT;
      end else
        cnt_n = cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/btn_event_scheduler.sv
// btn_event_scheduler: button events merged round-robin onto one valid/ready stream
import btn_sched_pkg::*;
module btn_event_scheduler #(
  parameter int N_BTN = 4,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W = 25,
  localparam int ID_W = $clog2(N_BTN)
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_BTN-1:0] pb_state,
  input  logic [N_BTN-1:0] pb_down,
  input  logic rpt_en,
  output logic cmd_valid,
  input  logic cmd_ready,
  output logic [ID_W-1:0] cmd_id,
  output logic cmd_rpt,
  output logic evt_drop
);
  logic [N_BTN-1:0] ev_press, ev_rpt, ev, pend, pend_rpt, gnt_vec;
  logic [ID_W-1:0] last, g;
  logic found, free, drop;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_repeat_timer #(
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W(CNT_W)
    ) u_tmr (
      .clk(clk),
      .rst(rst),
      .pb_state(pb_state[i]),
      .pb_down(pb_down[i]),
      .rpt_en(rpt_en),
      .evt_press(ev_press[i]),
      .evt_rpt(ev_rpt[i])
    );
  end
  // round-robin search from last+1; scanning downward leaves the nearest hit in g
  always_comb begin
    ev = ev_press | ev_rpt;
    free = !cmd_valid || cmd_ready;
    g = '0;
    found = 1'b0;
    for (int k = N_BTN; k >= 1; k--)
      if (pend[(int'(last) + k) % N_BTN]) begin
        g = ID_W'((int'(last) + k) % N_BTN);
        found = 1'b1;
      end
    gnt_vec = (free && found) ? {{(N_BTN-1){1'b0}}, 1'b1} << g : '0;
    drop = |(ev & pend & ~gnt_vec);
  end
  // pending store, drop pulse and output register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= '0;
      pend_rpt <= '0;
      evt_drop <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_id <= '0;
      cmd_rpt <= 1'b0;
      last <= ID_W'(N_BTN - 1);
    end else begin
      pend <= ev | (pend & ~gnt_vec);
      pend_rpt <= ev_rpt | (~ev & pend_rpt);
      evt_drop <= drop;
      if (free) begin
        cmd_valid <= found;
        if (found) begin
          cmd_id <= g;
          cmd_rpt <= pend_rpt[g];
          last <= g;
        end
      end
    end
endmodule

// File: tb/tb_btn_event_scheduler.sv
// tb_btn_event_scheduler: table vectors plus scoreboard for the event scheduler
module tb_btn_event_scheduler;
  logic clk = 1'b0, rst = 1'b1, rpt_en = 1'b1, cmd_ready = 1'b1;
  logic [3:0] pb_state = '0, pb_down = '0;
  logic cmd_valid, cmd_rpt, evt_drop;
  logic [1:0] cmd_id;
  int checks = 0, errors = 0;
  typedef struct {logic [1:0] id; logic rpt;} exp_t;
  typedef struct {logic [3:0] dn; logic ev; logic [1:0] eid;} vec_t;
  exp_t sb[$];
  vec_t tbl[16];
  always #5 clk = ~clk;
  btn_event_scheduler #(.N_BTN(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .pb_state(pb_state), .pb_down(pb_down), .rpt_en(rpt_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_rpt(cmd_rpt),
    .evt_drop(evt_drop)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int id, input logic rpt);
    exp_t e;
    e.id = 2'(id);
    e.rpt = rpt;
    sb.push_back(e);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    pb_down = '0;
    pb_state = '0;
    rpt_en = 1'b1;
    cmd_ready = 1'b1;
    sb.delete();
    step;
    step;
    rst = 1'b0;
  endtask
  // scoreboard: every accepted command must match the oldest expected one
  always @(negedge clk)
    if (!rst && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got id %0d rpt %0d, expected no command", cmd_id, cmd_rpt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_id", int'(cmd_id), int'(e.id));
        chk("sb_rpt", int'(cmd_rpt), int'(e.rpt));
      end
    end
  task automatic hold_test(input logic en);
    logic exp_v;
    do_reset;
    pb_down = 4'b0010;
    pb_state = 4'b0010;
    rpt_en = en;
    push(1, 1'b0);
    if (en) for (int k = 0; k < 6; k++) push(1, 1'b1);
    for (int c = 1; c <= 34; c++) begin
      step;
      pb_down = '0;
      if (c == 31) pb_state = '0;
      exp_v = (c == 2) || (en && c >= 10 && c <= 30 && (c - 10) % 4 == 0);
      chk(en ? "hold_valid" : "hold_norpt_valid", int'(cmd_valid), int'(exp_v));
      if (exp_v) chk("hold_rpt", int'(cmd_rpt), int'(c != 2));
    end
  endtask
  initial begin
    tbl[0] = '{4'b1111, 1'b0, 2'd0};  tbl[1] = '{4'b0000, 1'b1, 2'd0};
    tbl[2] = '{4'b0000, 1'b1, 2'd1};  tbl[3] = '{4'b0000, 1'b1, 2'd2};
    tbl[4] = '{4'b0000, 1'b1, 2'd3};  tbl[5] = '{4'b0000, 1'b0, 2'd0};
    tbl[6] = '{4'b1111, 1'b0, 2'd0};  tbl[7] = '{4'b0000, 1'b1, 2'd0};
    tbl[8] = '{4'b0000, 1'b1, 2'd1};  tbl[9] = '{4'b0000, 1'b1, 2'd2};
    tbl[10] = '{4'b0000, 1'b1, 2'd3}; tbl[11] = '{4'b0000, 1'b0, 2'd0};
    tbl[12] = '{4'b0100, 1'b0, 2'd0}; tbl[13] = '{4'b0000, 1'b1, 2'd2};
    tbl[14] = '{4'b0000, 1'b0, 2'd0}; tbl[15] = '{4'b0000, 1'b0, 2'd0};
    step;
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_id", int'(cmd_id), 0);
    chk("rst_rpt", int'(cmd_rpt), 0);
    chk("rst_drop", int'(evt_drop), 0);
    do_reset;
    for (int i = 0; i < 16; i++) begin
      pb_down = tbl[i].dn;
      for (int b = 0; b < 4; b++) if (tbl[i].dn[b]) push(b, 1'b0);
      step;
      pb_down = '0;
      chk("vec_valid", int'(cmd_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("vec_id", int'(cmd_id), int'(tbl[i].eid));
        chk("vec_rpt", int'(cmd_rpt), 0);
      end
      chk("vec_drop", int'(evt_drop), 0);
    end
    hold_test(1'b1);
    hold_test(1'b0);
    do_reset;
    cmd_ready = 1'b0;
    pb_down = 4'b1000;
    push(3, 1'b0);
    step;
    pb_down = 4'b0001;
    push(0, 1'b0);
    step;
    pb_down = '0;
    chk("coal_valid", int'(cmd_valid), 1);
    chk("coal_id_c2", int'(cmd_id), 3);
    step;
    chk("coal_drop_c3", int'(evt_drop), 0);
    step;
    pb_down = 4'b0001;
    chk("coal_drop_c4", int'(evt_drop), 0);
    step;
    pb_down = '0;
    chk("coal_drop_c5", int'(evt_drop), 1);
    chk("coal_id_c5", int'(cmd_id), 3);
    step;
    chk("coal_drop_c6", int'(evt_drop), 0);
    chk("coal_id_c6", int'(cmd_id), 3);
    cmd_ready = 1'b1;
    step;
    chk("coal_next_valid", int'(cmd_valid), 1);
    chk("coal_next_id", int'(cmd_id), 0);
    step;
    chk("coal_single", int'(cmd_valid), 0);
    do_reset;
    cmd_ready = 1'b0;
    pb_down = 4'b1000;
    push(3, 1'b0);
    step;
    pb_down = '0;
    step;
    pb_down = 4'b0010;
    push(1, 1'b0);
    chk("stall_id_c2", int'(cmd_id), 3);
    step;
    pb_down = '0;
    chk("stall_id_c3", int'(cmd_id), 3);
    step;
    chk("stall_id_c4", int'(cmd_id), 3);
    chk("stall_valid_c4", int'(cmd_valid), 1);
    cmd_ready = 1'b1;
    step;
    chk("stall_next_valid", int'(cmd_valid), 1);
    chk("stall_next_id", int'(cmd_id), 1);
    step;
    chk("stall_done", int'(cmd_valid), 0);
    do_reset;
    cmd_ready = 1'b0;
    pb_down = 4'b0001;
    push(0, 1'b0);
    step;
    pb_down = 4'b0110;
    pb_state = 4'b0110;
    step;
    pb_down = '0;
    chk("rstm_id0", int'(cmd_id), 0);
    chk("rstm_valid", int'(cmd_valid), 1);
    for (int c = 3; c <= 10; c++) step;
    chk("drop_multi", int'(evt_drop), 1);
    step;
    chk("drop_single_pulse", int'(evt_drop), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", int'(cmd_valid), 0);
    chk("async_id", int'(cmd_id), 0);
    chk("async_rpt", int'(cmd_rpt), 0);
    sb.delete();
    step;
    rst = 1'b0;
    pb_state = '0;
    cmd_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step;
      chk("post_rst_idle", int'(cmd_valid), 0);
    end
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
